// File: rtl/p405s_lit_cntl_dcd.sv
// Decode-side literal-control producer: registers one instruction, decodes its immediate form and
// sequences two-beat DCR moves. Define P405S_LIT_PARITY_EN to register even parity on litPar.
module p405s_lit_cntl_dcd #(
   parameter logic [0:4]  IDLE_LITCNTL = 5'b00100,
   parameter int unsigned DCR_BEATS    = 2
) (
   input  logic         CB,
   input  logic         reset,
   input  logic         instVld,
   input  logic [0:31]  instr,
   output logic         dcdRdy,
   input  logic         exeHold,
   input  logic         flush,
   output logic         litVld,
   output logic [0:4]   litCntl,
   output logic [11:31] PCL_dcdImmd,
   output logic         litPar
);

   typedef enum logic [1:0] {IDLE, DCR_ADDR, DCR_DATA} state_t;

   state_t        state;
   state_t        nextState;
   logic          accept;
   logic          litVld_p0;
   logic [0:4]    litCntl_p0;
   logic [11:31]  dcdImmd_p0;
   logic          unusedRtRa;

   function automatic logic [0:4] decodeLit(input logic [0:5] opcd, input logic [0:9] xo);
      logic [0:4] lit;
      lit = IDLE_LITCNTL;
      case (opcd) inside
         6'd7, 6'd8, 6'd12, 6'd14, [6'd32:6'd47]: lit = 5'b10000;
         6'd15, 6'd25, 6'd27, 6'd29:              lit = 5'b11100;
         6'd24, 6'd26, 6'd28:                     lit = 5'b00000;
         6'd20, 6'd21:                            lit = 5'b00010;
         6'd31: begin
            case (xo)
               10'd339, 10'd467, 10'd323, 10'd451: lit = 5'b00001;
               10'd146:                            lit = 5'b00101;
               default:                            lit = IDLE_LITCNTL;
            endcase
         end
         default: lit = IDLE_LITCNTL;
      endcase
      return lit;
   endfunction

   function automatic logic isDcr(input logic [0:5] opcd, input logic [0:9] xo);
      return (opcd == 6'd31) && ((xo == 10'd323) || (xo == 10'd451));
   endfunction

   function automatic logic evenPar(input logic [0:4] cntl, input logic [11:31] immd);
      return ^{cntl, immd};
   endfunction

   // RT/RA fields play no part in literal generation
   assign unusedRtRa = ^instr[6:10];

   // DCR_DATA frees the slot in the cycle it retires, allowing a back-to-back load
   assign dcdRdy = ~reset & ~flush & ~exeHold & ((state == IDLE) || (state == DCR_DATA));
   assign accept = instVld & dcdRdy;

   // Stage p0: next literal controls from FSM beat or newly accepted instruction
   always_comb begin
      nextState  = IDLE;
      litVld_p0  = 1'b0;
      litCntl_p0 = IDLE_LITCNTL;
      dcdImmd_p0 = PCL_dcdImmd;
      if (state == DCR_ADDR) begin
         nextState  = DCR_DATA;
         litVld_p0  = 1'b1;
         litCntl_p0 = 5'b00100;
      end else if (accept) begin
         litVld_p0  = 1'b1;
         litCntl_p0 = decodeLit(instr[0:5], instr[21:30]);
         dcdImmd_p0 = instr[11:31];
         if (isDcr(instr[0:5], instr[21:30]) && (DCR_BEATS == 2))
            nextState = DCR_ADDR;
      end
   end

   // Stage p1: output register toward EXE
   always_ff @(posedge CB) begin
      if (reset) begin
         state       <= IDLE;
         litVld      <= 1'b0;
         litCntl     <= IDLE_LITCNTL;
         PCL_dcdImmd <= '0;
      end else if (flush) begin
         state       <= IDLE;
         litVld      <= 1'b0;
         litCntl     <= IDLE_LITCNTL;
      end else if (!exeHold) begin
         state       <= nextState;
         litVld      <= litVld_p0;
         litCntl     <= litCntl_p0;
         PCL_dcdImmd <= dcdImmd_p0;
      end
   end

`ifdef P405S_LIT_PARITY_EN
   always_ff @(posedge CB) begin
      if (reset || flush)
         litPar <= 1'b0;
      else if (!exeHold)
         litPar <= evenPar(litCntl_p0, dcdImmd_p0);
   end
`else
   assign litPar = 1'b0;
`endif

endmodule

// File: tb/tb_p405s_lit_cntl_dcd.sv
// Scoreboard bench for p405s_lit_cntl_dcd: driver predicts beats per accepted instruction,
// a negedge monitor compares every beat EXE consumes plus readiness and idle outputs.
module tb_p405s_lit_cntl_dcd;

   logic         CB = 1'b0;
   logic         reset = 1'b1;
   logic         instVld = 1'b0;
   logic [0:31]  instr = '0;
   logic         exeHold = 1'b0;
   logic         flush = 1'b0;
   logic         dcdRdy;
   logic         litVld;
   logic [0:4]   litCntl;
   logic [11:31] PCL_dcdImmd;
   logic         litPar;

   typedef struct {
      logic [4:0]  cntl;
      logic [20:0] immd;
      logic        par;
      int          born;
   } beat_t;

   beat_t       expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          pending = 0;
   int          cyc = 0;
   bit          expRdy = 1'b0;
   bit          monOn = 1'b0;
   logic [20:0] idleImmd = '0;

   int opTab[22] = '{7, 8, 12, 14, 32, 40, 47, 15, 25, 27, 29, 24, 26, 28, 20, 21, 31, 31, 31, 0, 3, 63};
   int xoTab[6]  = '{339, 467, 323, 451, 146, 266};

   always #5 CB = ~CB;
   always @(posedge CB) cyc <= cyc + 1;

   p405s_lit_cntl_dcd dut (
      .CB(CB), .reset(reset), .instVld(instVld), .instr(instr), .dcdRdy(dcdRdy),
      .exeHold(exeHold), .flush(flush), .litVld(litVld), .litCntl(litCntl),
      .PCL_dcdImmd(PCL_dcdImmd), .litPar(litPar)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [4:0] refLit(input logic [31:0] w);
      int op;
      int xo;
      op = int'(w >> 26);
      xo = int'((w >> 1) & 32'h3FF);
      if ((op inside {7, 8, 12, 14}) || (op >= 32 && op <= 47)) return 5'b10000;
      if (op inside {15, 25, 27, 29}) return 5'b11100;
      if (op inside {24, 26, 28}) return 5'b00000;
      if (op inside {20, 21}) return 5'b00010;
      if (op == 31 && (xo inside {339, 467, 323, 451})) return 5'b00001;
      if (op == 31 && xo == 146) return 5'b00101;
      return 5'b00100;
   endfunction

   function automatic int refBeats(input logic [31:0] w);
      int op;
      int xo;
      op = int'(w >> 26);
      xo = int'((w >> 1) & 32'h3FF);
      return (op == 31 && (xo inside {323, 451})) ? 2 : 1;
   endfunction

   function automatic beat_t mkBeat(input logic [4:0] c, input logic [20:0] im, input int b);
      beat_t e;
      e.cntl = c;
      e.immd = im;
`ifdef P405S_LIT_PARITY_EN
      e.par = ^{c, im};
`else
      e.par = 1'b0;
`endif
      e.born = b;
      return e;
   endfunction

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      w = $urandom;
      w[31:26] = 6'(opTab[$urandom_range(0, 21)]);
      if (w[31:26] == 6'd31) w[10:1] = 10'(xoTab[$urandom_range(0, 5)]);
      return w;
   endfunction

   task automatic cycle(input bit v, input logic [31:0] w, input bit h, input bit f, output bit acc);
      @(posedge CB);
      #1;
      instVld = v;
      instr   = w;
      exeHold = h;
      flush   = f;
      expRdy  = (pending <= 1) && !h && !f;
      acc     = v && expRdy;
      if (acc) begin
         expQ.push_back(mkBeat(refLit(w), w[20:0], cyc));
         if (refBeats(w) == 2) expQ.push_back(mkBeat(5'b00100, w[20:0], cyc));
      end
      if (f) pending = 0;
      else if (!h) begin
         if (pending > 0) pending--;
         if (acc) pending = refBeats(w);
      end
   endtask

   always @(negedge CB) begin
      if (monOn) begin
         bit shown;
         shown = (expQ.size() != 0) && (expQ[0].born < cyc);
         chk("dcdRdy", 64'(dcdRdy), 64'(expRdy));
         chk("litVld", 64'(litVld), 64'(shown));
         if (litVld && shown) begin
            chk("beat", {litCntl, PCL_dcdImmd, litPar}, {expQ[0].cntl, expQ[0].immd, expQ[0].par});
            if (!flush && !exeHold) begin
               idleImmd = expQ[0].immd;
               void'(expQ.pop_front());
            end
         end else if (!litVld) begin
            chk("idleOut", {litCntl, PCL_dcdImmd}, {5'b00100, idleImmd});
         end
         if (flush) begin
            if (expQ.size() != 0) idleImmd = expQ[0].immd;
            expQ.delete();
         end
      end
   end

   initial begin
      bit acc;
      bit have;
      logic [31:0] cur;
      repeat (2) @(posedge CB);
      #1;
      reset  = 1'b0;
      expRdy = 1'b1;
      monOn  = 1'b1;
      @(negedge CB);
      chk("resetPar", 64'(litPar), 64'd0);

      // directed: addi, oris, rlwinm, ori parity
      cycle(1, 32'h3860FFFC, 0, 0, acc);
      cycle(1, 32'h6463ABCD, 0, 0, acc);
      cycle(1, 32'h5463083E, 0, 0, acc);
      cycle(1, 32'h60000001, 0, 0, acc);
      cycle(0, 32'h0, 0, 0, acc);
      // mtdcr with beat1 held for 3 cycles, then back-to-back addi
      cycle(1, 32'h7C6A0386, 0, 0, acc);
      repeat (3) cycle(0, 32'h0, 1, 0, acc);
      cycle(1, 32'h3860FFFC, 0, 0, acc);
      cycle(1, 32'h3860FFFC, 0, 0, acc);
      cycle(1, 32'h3860FFFC, 0, 0, acc);
      cycle(0, 32'h0, 0, 0, acc);
      // flush in DCR_ADDR, then hold+flush in DCR_ADDR
      cycle(1, 32'h7C6A0386, 0, 0, acc);
      cycle(0, 32'h0, 0, 1, acc);
      cycle(0, 32'h0, 0, 0, acc);
      cycle(1, 32'h7C6A0386, 0, 0, acc);
      cycle(0, 32'h0, 1, 1, acc);
      cycle(1, 32'h7C000124, 0, 0, acc);
      cycle(0, 32'h0, 0, 0, acc);

      // random traffic; a rejected instruction stays presented upstream
      have = 1'b0;
      cur  = '0;
      for (int i = 0; i < 4000; i++) begin
         if (!have && ($urandom_range(0, 9) < 7)) begin
            cur  = randInstr();
            have = 1'b1;
         end
         cycle(have, cur, ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0), acc);
         if (acc) have = 1'b0;
      end
      repeat (4) cycle(0, 32'h0, 0, 0, acc);
      @(negedge CB);
      chk("drained", 64'(expQ.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
